imem_fetch_arbiter: RTL and testbench
=====================================

Name: imem_fetch_arbiter

Overview:
- Sequences and shares the single byte-wide port of the instruction memory (DEPTH bytes, big-endian words) between two requesters.
- Requester 1 is the IF-stage fetch, which needs 32-bit words assembled from 4 byte reads.
- Requester 2 is the program loader/debug port, which does single-byte writes.
- Sits between the IF stage and the byte-array memory; replaces direct combinational word reads with a registered, arbitrated access.

Parameters:
- DEPTH, 1024, instruction memory size in bytes.
- AW, 10, memory byte-address width (log2 DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_req  in  1  fetch request; held high with fetch_addr stable until fetch_valid.
- fetch_addr  in  32  byte address of the instruction word.
- fetch_flush  in  1  abort any in-progress fetch.
- fetch_busy  out  1  high while a fetch burst is in progress (states RD, LAST).
- fetch_valid  out  1  one-cycle pulse: inst/fetch_err valid.
- fetch_err  out  1  qualifies fetch_valid: misaligned or out-of-range address.
- inst  out  32  assembled word, {byte0, byte1, byte2, byte3}.
- ld_req  in  1  loader write request.
- ld_addr  in  AW  loader byte address.
- ld_wdata  in  8  loader byte data.
- ld_ack  out  1  one-cycle pulse: write completed.
- mem_addr  out  AW  memory byte address, registered.
- mem_we  out  1  memory write enable, registered.
- mem_wdata  out  8  memory write data, registered.
- mem_rdata  in  8  memory read data; returns data for the address presented in the previous cycle.

Behaviour:
- Reset: state IDLE; cnt 0; every output 0 (inst = 32'h0).
- rst has priority over everything, including mid-burst; no valid or ack is produced for an aborted operation.

States and transitions:
- IDLE
  - Samples requests.
  - ld_req wins over fetch_req when both are high (fixed priority, default build).
  - Loader grant: mem_addr <= ld_addr, mem_wdata <= ld_wdata, mem_we <= 1 for one cycle, state WR.
  - Fetch grant, bad address (fetch_addr[1:0] != 0, or fetch_addr > DEPTH-4): state ERR, no memory access.
  - Fetch grant, good address: latch base = fetch_addr[AW-1:0]; mem_addr <= base; cnt <= 0; state RD.
- WR
  - mem_we <= 0; ld_ack <= 1 (visible the next cycle); state IDLE.
- RD
  - Each cycle: capture mem_rdata into byte (cnt-1) when cnt > 0.
  - mem_addr <= base + cnt + 1; cnt++.
  - When cnt = 3: state LAST.
- LAST
  - Capture byte 3; fetch_valid <= 1; fetch_err <= 0; state IDLE.
- ERR
  - fetch_valid <= 1, fetch_err <= 1, inst <= 0; state IDLE.

Timing:
- Fetch latency: request sampled in IDLE at cycle 0 → fetch_valid high in cycle 6.
- Loader latency: ld_ack high in cycle 2.
- inst holds its value until the next successful fetch or ERR.

Boundary conditions:
- fetch_flush in RD or LAST: state IDLE next cycle; no fetch_valid; partial bytes discarded; inst unchanged.
- fetch_flush in IDLE: the fetch request is ignored that cycle.
- fetch_flush does not affect WR.
- The IDLE grant can only start the cycle after fetch_valid or ld_ack; no back-to-back grant in the pulse cycle.
- Requests arriving during a burst wait; bursts are never preempted.
- Address base+3 never wraps: out-of-range addresses are rejected in IDLE.

Optional Feature:
- Macro: IMEM_ARB_RR_EN.
- Defined:
  - Round-robin arbitration on simultaneous ld_req and fetch_req in IDLE.
  - A last_gnt flop (reset = fetch, so the loader wins the first tie) gives priority to the requester not served last.
  - last_gnt updates on every grant.
- Undefined: fixed loader priority; no last_gnt flop.

Test Plan:
- Loader writes 8'h12, 8'h34, 8'h56, 8'h78 to addr 0..3, then fetch addr 0 → ld_ack ×4; fetch_valid in cycle 6 after sampling; inst = 32'h12345678; fetch_err = 0.
- Fetch addr 32'h2 → fetch_valid and fetch_err high 2 cycles after sampling; inst = 0; mem_addr unchanged.
- Fetch addr 1021 (DEPTH 1024) → error pulse.
- Fetch addr 1020 → normal word returned.
- Assert fetch_flush at cycle 3 of a fetch to addr 4 → no fetch_valid; next fetch to addr 4 returns the correct word.
- ld_req and fetch_req rise in the same cycle, held for two grants:
  - Default build → loader first, then fetch.
  - IMEM_ARB_RR_EN build → loader first, then fetch; a second tie → fetch first.
- Assert rst mid-RD → all outputs 0 next cycle; state IDLE; a subsequent fetch of addr 0 returns 32'h12345678.

Source files
------------

// File: rtl/imem_fetch_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : imem_fetch_arbiter
//  Description : Shares the single byte-wide instruction-memory port between
//                the IF-stage word fetch (4 sequential byte reads assembled
//                big-endian) and the loader/debug byte-write port.
//                Optional macro IMEM_ARB_RR_EN selects round-robin arbitration
//                on simultaneous requests; otherwise the loader has fixed
//                priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_arbiter #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    // IF-stage fetch port
    input  logic          fetch_req,
    input  logic [31:0]   fetch_addr,
    input  logic          fetch_flush,
    output logic          fetch_busy,
    output logic          fetch_valid,
    output logic          fetch_err,
    output logic [31:0]   inst,
    // loader write port
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_wdata,
    output logic          ld_ack,
    // byte memory port
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_wr   = 3'd1;
    localparam logic [2:0] c_st_rd   = 3'd2;
    localparam logic [2:0] c_st_last = 3'd3;
    localparam logic [2:0] c_st_err  = 3'd4;

    // Highest word-aligned address whose last byte still lies inside memory.
    localparam logic [31:0] c_max_addr = 32'(DEPTH - 4);

    logic [2:0]    r_state;
    logic [1:0]    r_cnt;
    logic [AW-1:0] r_base;
    logic [23:0]   r_buf;     // bytes 0..2 of the word being assembled

    logic          w_idle;
    logic          w_pulse;
    logic          w_fetch_cand;
    logic          w_addr_bad;
    logic          w_ld_gnt;
    logic          w_fetch_gnt;

    assign w_idle       = (r_state == c_st_idle);
    // Requesters still hold their request during the completion pulse, so no
    // new grant is allowed in that cycle.
    assign w_pulse      = fetch_valid | ld_ack;
    assign w_fetch_cand = fetch_req & ~fetch_flush;
    assign w_addr_bad   = (fetch_addr[1:0] != 2'b00) || (fetch_addr > c_max_addr);
    assign fetch_busy   = (r_state == c_st_rd) || (r_state == c_st_last);

`ifdef IMEM_ARB_RR_EN
    logic r_last_gnt;   // 1: loader was served last, 0: fetch was served last

    assign w_ld_gnt    = w_idle & ~w_pulse & ld_req & (~w_fetch_cand | ~r_last_gnt);
    assign w_fetch_gnt = w_idle & ~w_pulse & w_fetch_cand & (~ld_req | r_last_gnt);

    // Remember which requester won the most recent grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_gnt <= 1'b0;
        end else if (w_ld_gnt) begin
            r_last_gnt <= 1'b1;
        end else if (w_fetch_gnt) begin
            r_last_gnt <= 1'b0;
        end
    end
`else
    assign w_ld_gnt    = w_idle & ~w_pulse & ld_req;
    assign w_fetch_gnt = w_idle & ~w_pulse & w_fetch_cand & ~ld_req;
`endif

    // Arbitration, burst sequencing and registered memory/requester outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_cnt       <= 2'd0;
            r_base      <= '0;
            r_buf       <= '0;
            fetch_valid <= 1'b0;
            fetch_err   <= 1'b0;
            inst        <= 32'h0;
            ld_ack      <= 1'b0;
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_wdata   <= 8'h0;
        end else begin
            fetch_valid <= 1'b0;
            ld_ack      <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_ld_gnt) begin
                        mem_addr  <= ld_addr;
                        mem_wdata <= ld_wdata;
                        mem_we    <= 1'b1;
                        r_state   <= c_st_wr;
                    end else if (w_fetch_gnt) begin
                        if (w_addr_bad) begin
                            r_state <= c_st_err;
                        end else begin
                            r_base   <= fetch_addr[AW-1:0];
                            mem_addr <= fetch_addr[AW-1:0];
                            r_cnt    <= 2'd0;
                            r_state  <= c_st_rd;
                        end
                    end
                end
                c_st_wr: begin
                    mem_we  <= 1'b0;
                    ld_ack  <= 1'b1;
                    r_state <= c_st_idle;
                end
                c_st_rd: begin
                    if (fetch_flush) begin
                        r_cnt   <= 2'd0;
                        r_state <= c_st_idle;
                    end else begin
                        // Read data lags the address by one cycle, so the
                        // first capture happens once cnt has advanced.
                        if (r_cnt != 2'd0) begin
                            r_buf <= {r_buf[15:0], mem_rdata};
                        end
                        if (r_cnt == 2'd3) begin
                            // Address base+3 is already presented; hold it.
                            r_state <= c_st_last;
                        end else begin
                            mem_addr <= r_base + AW'(r_cnt) + AW'(1);
                        end
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                c_st_last: begin
                    if (fetch_flush) begin
                        r_state <= c_st_idle;
                    end else begin
                        inst        <= {r_buf, mem_rdata};
                        fetch_valid <= 1'b1;
                        fetch_err   <= 1'b0;
                        r_state     <= c_st_idle;
                    end
                end
                c_st_err: begin
                    inst        <= 32'h0;
                    fetch_valid <= 1'b1;
                    fetch_err   <= 1'b1;
                    r_state     <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_imem_fetch_arbiter
//  Description : Scoreboard bench for imem_fetch_arbiter with a registered
//                byte-memory model. Directed stimulus pushes expected pulses
//                (cycle, error flag, word) into queues; a negedge monitor pops
//                and compares whenever fetch_valid or ld_ack is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_arbiter;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_req;
    logic [31:0]   fetch_addr;
    logic          fetch_flush;
    logic          fetch_busy;
    logic          fetch_valid;
    logic          fetch_err;
    logic [31:0]   inst;
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_wdata;
    logic          ld_ack;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    imem_fetch_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_flush(fetch_flush),
        .fetch_busy (fetch_busy),
        .fetch_valid(fetch_valid),
        .fetch_err  (fetch_err),
        .inst       (inst),
        .ld_req     (ld_req),
        .ld_addr    (ld_addr),
        .ld_wdata   (ld_wdata),
        .ld_ack     (ld_ack),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Byte memory: registered read, data for the previous cycle's address.
    logic [7:0] mem [DEPTH];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    // Posedge counter; at a negedge it equals the number of the last posedge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          err;
        logic [31:0] inst;
        int          cyc;
    } fexp_t;

    fexp_t fq[$];
    int    ldq[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: every completion pulse must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (fetch_valid) begin
                if (fq.size() == 0) begin
                    check("unexpected_fetch_valid", 64'd1, 64'd0);
                end else begin
                    fexp_t e;
                    e = fq.pop_front();
                    check("fetch_cycle", 64'(cyc), 64'(e.cyc));
                    check("fetch_err", 64'(fetch_err), 64'(e.err));
                    check("fetch_inst", 64'(inst), 64'(e.inst));
                end
            end
            if (ld_ack) begin
                if (ldq.size() == 0) begin
                    check("unexpected_ld_ack", 64'd1, 64'd0);
                end else begin
                    int ec;
                    ec = ldq.pop_front();
                    check("ld_ack_cycle", 64'(cyc), 64'(ec));
                end
            end
        end
    end

    function automatic void push_fetch(input bit err, input logic [31:0] w, input int c);
        fexp_t e;
        e.err  = err;
        e.inst = w;
        e.cyc  = c;
        fq.push_back(e);
    endfunction

    task automatic do_load(input logic [AW-1:0] a, input logic [7:0] d);
        int  c;
        bit  done;
        @(negedge clk);
        c = cyc;
        ld_req = 1'b1; ld_addr = a; ld_wdata = d;
        ldq.push_back(c + 2);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (ld_ack) begin ld_req = 1'b0; done = 1'b1; end
        end
        if (!done) begin ld_req = 1'b0; check("ld_timeout", 64'd0, 64'd1); end
    endtask

    // idle_flush: hold fetch_flush with the request for its first cycle.
    task automatic do_fetch(input logic [31:0] a, input bit err, input logic [31:0] w, input bit idle_flush);
        int  c;
        bit  done;
        @(negedge clk);
        c = cyc;
        fetch_req = 1'b1; fetch_addr = a; fetch_flush = idle_flush;
        push_fetch(err, w, c + (err ? 2 : 6) + (idle_flush ? 1 : 0));
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            fetch_flush = 1'b0;
            if (fetch_valid) begin fetch_req = 1'b0; done = 1'b1; end
        end
        if (!done) begin fetch_req = 1'b0; check("fetch_timeout", 64'd0, 64'd1); end
    endtask

    task automatic do_tie(input logic [AW-1:0] la, input logic [7:0] d, input logic [31:0] fa,
                          input logic [31:0] w, input bit ld_first);
        int c;
        bit ld_done, f_done;
        @(negedge clk);
        c = cyc;
        ld_req = 1'b1; ld_addr = la; ld_wdata = d;
        fetch_req = 1'b1; fetch_addr = fa;
        ldq.push_back(ld_first ? c + 2 : c + 9);
        push_fetch(1'b0, w, ld_first ? c + 9 : c + 6);
        ld_done = 1'b0; f_done = 1'b0;
        for (int i = 0; i < 40 && !(ld_done && f_done); i++) begin
            @(negedge clk);
            if (ld_ack)      begin ld_req = 1'b0;    ld_done = 1'b1; end
            if (fetch_valid) begin fetch_req = 1'b0; f_done  = 1'b1; end
        end
        if (!(ld_done && f_done)) begin
            ld_req = 1'b0; fetch_req = 1'b0;
            check("tie_timeout", 64'd0, 64'd1);
        end
    endtask

    initial begin
        int c;
        bit tie2_ld_first;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
        rst = 1'b1;
        fetch_req = 1'b0; fetch_addr = 32'h0; fetch_flush = 1'b0;
        ld_req = 1'b0; ld_addr = '0; ld_wdata = 8'h0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              64'({fetch_busy, fetch_valid, fetch_err, inst, ld_ack, mem_addr, mem_we, mem_wdata}), 64'd0);
        rst = 1'b0;

        do_load(10'd0, 8'h12);   do_load(10'd1, 8'h34);
        do_load(10'd2, 8'h56);   do_load(10'd3, 8'h78);
        do_load(10'd4, 8'hA1);   do_load(10'd5, 8'hB2);
        do_load(10'd6, 8'hC3);   do_load(10'd7, 8'hD4);
        do_load(10'd1020, 8'hDE); do_load(10'd1021, 8'hAD);
        do_load(10'd1022, 8'hBE); do_load(10'd1023, 8'hEF);

        do_fetch(32'd0, 1'b0, 32'h12345678, 1'b0);
        check("addr_after_fetch0", 64'(mem_addr), 64'd3);

        // Rejected addresses: misaligned, past the end, and high bits set.
        do_fetch(32'h2, 1'b1, 32'h0, 1'b0);
        check("err_mem_addr_unchanged", 64'(mem_addr), 64'd3);
        do_fetch(32'd1021, 1'b1, 32'h0, 1'b0);
        do_fetch(32'd1024, 1'b1, 32'h0, 1'b0);
        do_fetch(32'h1000_0000, 1'b1, 32'h0, 1'b0);
        check("err_mem_addr_still", 64'(mem_addr), 64'd3);

        do_fetch(32'd1020, 1'b0, 32'hDEADBEEF, 1'b0);

        // Flush in the fourth cycle of a burst: no pulse, inst kept.
        @(negedge clk);
        c = cyc;
        fetch_req = 1'b1; fetch_addr = 32'd4;
        while (cyc < c + 3) @(negedge clk);
        check("busy_before_flush", 64'(fetch_busy), 64'd1);
        fetch_flush = 1'b1; fetch_req = 1'b0;
        @(negedge clk);
        fetch_flush = 1'b0;
        check("busy_after_flush", 64'(fetch_busy), 64'd0);
        repeat (8) @(negedge clk);
        check("inst_kept_after_flush", 64'(inst), 64'(32'hDEADBEEF));

        // Flush in IDLE delays the grant by one cycle.
        do_fetch(32'd4, 1'b0, 32'hA1B2C3D4, 1'b1);

        // Tie after a fetch: loader wins in both builds.
        do_tie(10'd8, 8'h5A, 32'd0, 32'h12345678, 1'b1);

        // Tie after a lone loader grant: round-robin hands it to the fetch.
        do_load(10'd9, 8'h6B);
`ifdef IMEM_ARB_RR_EN
        tie2_ld_first = 1'b0;
`else
        tie2_ld_first = 1'b1;
`endif
        do_tie(10'd10, 8'h7C, 32'd4, 32'hA1B2C3D4, tie2_ld_first);

        // Reset in the middle of a burst clears every output.
        @(negedge clk);
        c = cyc;
        fetch_req = 1'b1; fetch_addr = 32'd4;
        while (cyc < c + 3) @(negedge clk);
        rst = 1'b1; fetch_req = 1'b0;
        @(negedge clk);
        check("reset_midburst_outputs",
              64'({fetch_busy, fetch_valid, fetch_err, inst, ld_ack, mem_addr, mem_we, mem_wdata}), 64'd0);
        rst = 1'b0;

        do_fetch(32'd0, 1'b0, 32'h12345678, 1'b0);
        do_fetch(32'd8, 1'b0, 32'h5A6B7C00, 1'b0);

        repeat (10) @(negedge clk);
        check("fetch_queue_drained", 64'(fq.size()), 64'd0);
        check("ld_queue_drained", 64'(ldq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the bench always ends on its own.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "time limit reached");
    end

endmodule
`default_nettype wire
